branch_redirect_ctrl: RTL

Branch redirect controller. It sits between the execute-stage branch unit and the fetch/decode front end. A resolved taken branch or jump, or a trap, becomes a registered redirect request to fetch over a valid/ready handshake. While the request is outstanding, the block flushes the younger pipeline stages, stalls execute, and then drains a fixed number of flush cycles. It also flags misaligned branch targets and counts taken branches.

---
 rtl/riscv.sv | 10 +
 rtl/branch_redirect_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/riscv.sv
// rtl/riscv.sv - shared core types and constants for the front-end redirect path
package riscv;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {BR_IDLE, BR_REQ, BR_DRAIN} br_state_t;

  localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - turns taken branches/traps into a fetch redirect with flush/stall
module branch_redirect_ctrl
  import riscv::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             exe_v_i,
  input  logic             branch_v_i,
  input  logic [XLEN-1:0]  pc_nxt_i,
  input  logic             trap_v_i,
  input  logic [XLEN-1:0]  trap_pc_i,
  input  logic             redirect_ready_i,
  output logic             redirect_v_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             flush_o,
  output logic             stall_exe_o,
  output logic             exc_misaligned_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  localparam int DW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(FLUSH_CYCLES - 1);

  br_state_t        r_state;
  logic [DW-1:0]    r_drain_cnt;
  logic             r_redirect_v;
  logic [XLEN-1:0]  r_redirect_pc;
  logic             r_flush;
  logic             r_stall;
  logic             r_misaligned;
  logic [CNT_W-1:0] r_taken_cnt;

  logic w_branch;
  logic w_aligned;

  assign w_branch  = exe_v_i & branch_v_i;
  assign w_aligned = (pc_nxt_i[1:0] & INSTR_ALIGN_MASK) == 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= BR_IDLE;
      r_drain_cnt   <= '0;
      r_redirect_v  <= 1'b0;
      r_redirect_pc <= '0;
      r_flush       <= 1'b0;
      r_stall       <= 1'b0;
      r_misaligned  <= 1'b0;
      r_taken_cnt   <= '0;
    end else begin
      r_misaligned <= 1'b0;
      // A trap from any state (re)enters REQ; it also overrides a completing handshake.
      if (trap_v_i) begin
        r_state       <= BR_REQ;
        r_redirect_v  <= 1'b1;
        r_redirect_pc <= trap_pc_i;
        r_flush       <= 1'b1;
        r_stall       <= 1'b1;
      end else begin
        case (r_state)
          BR_IDLE: begin
            if (w_branch && w_aligned) begin
              r_state       <= BR_REQ;
              r_redirect_v  <= 1'b1;
              r_redirect_pc <= pc_nxt_i;
              r_flush       <= 1'b1;
              r_stall       <= 1'b1;
              r_taken_cnt   <= r_taken_cnt + 1'b1;
            end else if (w_branch) begin
              r_misaligned <= 1'b1;
            end
          end
          BR_REQ: begin
            if (r_redirect_v && redirect_ready_i) begin
              r_state      <= BR_DRAIN;
              r_redirect_v <= 1'b0;
              r_drain_cnt  <= DRAIN_LOAD;
            end
          end
          BR_DRAIN: begin
            if (r_drain_cnt == '0) begin
              r_state <= BR_IDLE;
              r_flush <= 1'b0;
              r_stall <= 1'b0;
            end else begin
              r_drain_cnt <= r_drain_cnt - 1'b1;
            end
          end
          default: begin
            r_state      <= BR_IDLE;
            r_redirect_v <= 1'b0;
            r_flush      <= 1'b0;
            r_stall      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign redirect_v_o     = r_redirect_v;
  assign redirect_pc_o    = r_redirect_pc;
  assign flush_o          = r_flush;
  assign stall_exe_o      = r_stall;
  assign exc_misaligned_o = r_misaligned;
  assign taken_cnt_o      = r_taken_cnt;

endmodule
